tse_cfg_arbiter: RTL and testbench
==================================

TSE_CFG_ARBITER -- requirements
Module: tse_cfg_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, number of BUSY-high cycles before a transfer is aborted (used only with TSE_ARB_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all logic SHALL be rising-edge clocked.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wr_rq[1:0]  in  2  per-requester write request; level, held until ack.
REQ-005 rd_rq[1:0]  in  2  per-requester read request; level, held until ack.
REQ-006 adr0, adr1  in  10 each  requester register address.
REQ-007 wdata0, wdata1  in  32 each  requester write data.
REQ-008 ack[1:0]  out  2  one-cycle transfer-complete pulse per requester.
REQ-009 rdata  out  32  read data; valid while any ack bit is high.
REQ-010 err  out  1  one-cycle pulse coincident with ack on an aborted transfer.
REQ-011 ADR_O  out  10  Avalon-MM address.
REQ-012 DAT_O  out  32  Avalon-MM write data.
REQ-013 DAT_I  in  32  Avalon-MM read data.
REQ-014 RD, WR  out  1 each  Avalon-MM read and write strobes.
REQ-015 BUSY  in  1  Avalon-MM waitrequest; a strobe SHALL be held while BUSY=1.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and DONE.
REQ-017 A requester i is pending when wr_rq[i] or rd_rq[i] is set.
REQ-018 In IDLE with at least one requester pending, the block SHALL grant one requester and move to ISSUE on the next edge.
REQ-019 Arbitration SHALL be round-robin: when both requesters are pending, the grant goes to the one not granted last.
REQ-020 When only one requester is pending, that requester SHALL be granted.
REQ-021 If wr_rq[i] and rd_rq[i] are both set, the block SHALL perform a write only.
REQ-022 In ISSUE, the block SHALL drive ADR_O, DAT_O (write only), and exactly one of WR or RD from the granted requester's inputs, all registered.
REQ-023 ISSUE SHALL persist while BUSY=1.
REQ-024 On an edge in ISSUE with BUSY=0, the block SHALL drop RD/WR, capture DAT_I into rdata (reads only) and enter DONE.
REQ-025 In DONE, ack[grant] SHALL be 1 for exactly one cycle, after which the block returns to IDLE.
REQ-026 Minimum latency SHALL be: request seen at edge N, strobe high in cycle N+1, ack high in cycle N+2 when BUSY=0.
REQ-027 Requesters SHALL drop their request in the ack cycle; pending state SHALL be sampled only in IDLE.
REQ-028 Request changes during ISSUE or DONE SHALL NOT affect the transfer in flight.
REQ-029 Outside ISSUE, RD=WR=0 and ADR_O/DAT_O=0.
REQ-030 After a write, rdata SHALL hold its previous value.

Reset
REQ-031 On reset, ack, err, RD, WR, ADR_O, DAT_O and rdata SHALL be 0 and the FSM SHALL be in IDLE.
REQ-032 On reset, the round-robin pointer SHALL favour requester 0 next.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer at that edge with no ack.

Configuration
REQ-034 With macro TSE_ARB_TIMEOUT_EN defined, a counter SHALL run in ISSUE.
REQ-035 With TSE_ARB_TIMEOUT_EN defined, after TIMEOUT_CYCLES consecutive BUSY=1 cycles the block SHALL drop the strobe, load rdata=32'hDEADBEEF, and enter DONE with ack and err both pulsed.
REQ-036 With TSE_ARB_TIMEOUT_EN undefined, ISSUE SHALL wait indefinitely and err SHALL be constant 0.

Verification
REQ-037 Single write, BUSY=0: wr_rq[0]=1, adr0=10'h008, wdata0=32'h0000_0003 -> WR=1 for 1 cycle with ADR_O=008 and DAT_O=3, then ack[0] for 1 cycle.
REQ-038 Read with wait states: rd_rq[1], adr1=10'h002, BUSY high 3 cycles, DAT_I=32'h1234_5678 -> RD held 4 cycles, then ack[1] with rdata=32'h12345678.
REQ-039 Contention: both requesters pending continuously after reset -> grants alternate 0,1,0,1 and each ack is a single-cycle pulse.
REQ-040 Reset mid-ISSUE with BUSY=1 -> RD=WR=0 on the next edge, no ack, and a subsequent pair of requests grants requester 0 first.
REQ-041 With TSE_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, BUSY held at 1 -> strobe drops after 16 cycles, then ack and err pulse together with rdata=32'hDEADBEEF.
REQ-042 With TSE_ARB_TIMEOUT_EN undefined and BUSY held at 1 for 2000 cycles -> strobe stays high and err stays 0.

Source files
------------

// File: rtl/tse_cfg_arbiter.sv
// Two-requester round-robin arbiter onto one Avalon-MM config port.
// Optional ISSUE watchdog: define TSE_ARB_TIMEOUT_EN to abort after TIMEOUT_CYCLES busy cycles.
module tse_cfg_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wr_rq,
  input  logic [1:0]  rd_rq,
  input  logic [9:0]  adr0,
  input  logic [9:0]  adr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [9:0]  ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        RD,
  output logic        WR,
  input  logic        BUSY
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic        wr;
    logic [9:0]  adr;
    logic [31:0] dat;
  } cfg_req_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t   state, state_nxt;
  logic     gnt, gnt_nxt;
  logic     rr_pref;
  logic     timeout;
  logic     xfer_done;
  logic [1:0] pend;
  cfg_req_t sel_req;

  assign pend      = wr_rq | rd_rq;
  assign xfer_done = (state == ISSUE) && (!BUSY || timeout);
  assign ack       = (state == DONE) ? (gnt ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    case (state)
      IDLE: if (|pend) begin
        state_nxt = ISSUE;
        gnt_nxt   = (&pend) ? rr_pref : pend[1];
      end
      ISSUE:   if (xfer_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write wins when a requester asserts both strobes.
  always_comb begin
    sel_req     = '0;
    sel_req.wr  = wr_rq[gnt_nxt];
    sel_req.adr = gnt_nxt ? adr1 : adr0;
    sel_req.dat = sel_req.wr ? (gnt_nxt ? wdata1 : wdata0) : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Requester inputs are captured at grant so later changes cannot disturb the bus cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_pref <= 1'b0;
      ADR_O   <= '0;
      DAT_O   <= '0;
      WR      <= 1'b0;
      RD      <= 1'b0;
      rdata   <= '0;
    end else if (state == IDLE && |pend) begin
      rr_pref <= ~gnt_nxt;
      ADR_O   <= sel_req.adr;
      DAT_O   <= sel_req.dat;
      WR      <= sel_req.wr;
      RD      <= ~sel_req.wr;
    end else if (xfer_done) begin
      ADR_O <= '0;
      DAT_O <= '0;
      WR    <= 1'b0;
      RD    <= 1'b0;
      if (timeout)  rdata <= ABORT_DATA;
      else if (RD)  rdata <= DAT_I;
    end
  end

`ifdef TSE_ARB_TIMEOUT_EN
  localparam int TO_CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_CW-1:0] to_cnt;
  logic             to_flag;

  // to_cnt holds the number of busy cycles already elapsed in this ISSUE.
  assign timeout = (state == ISSUE) && BUSY && (to_cnt == TO_CW'(TIMEOUT_CYCLES - 1));
  assign err     = (state == DONE) && to_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == ISSUE && BUSY && !timeout) to_cnt <= to_cnt + 1'b1;
      else                                    to_cnt <= '0;
      if (xfer_done) to_flag <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_tse_cfg_arbiter.sv
// Scoreboard bench for tse_cfg_arbiter: expected acks and strobes queued at stimulus time.
module tb_tse_cfg_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_rq, rd_rq;
  logic [9:0]  adr0, adr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        err;
  logic [9:0]  ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        RD, WR;
  logic        BUSY;

  always #5 clk = ~clk;

  tse_cfg_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .wr_rq(wr_rq), .rd_rq(rd_rq),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .err(err), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .DAT_I(DAT_I), .RD(RD), .WR(WR), .BUSY(BUSY)
  );

  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_stb;
  int   err_seen;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Completion side of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (|ack) begin
      if (sb.size() == 0) chk("ack_unexpected", ack, 0);
      else begin
        e = sb.pop_front();
        chk("ack_who", ack, e.ack);
        chk("ack_rdata", rdata, e.rdata);
        chk("ack_err", err, e.err);
      end
    end else if (err) chk("err_stray", err, 0);
  end

  // Watches the bus for n completions; first strobe cycle of each transfer is matched to gq.
  task automatic run_xfers(input int n, input int budget);
    int         got = 0;
    logic       prev_stb = 1'b0;
    logic [1:0] prev_ack = 2'b00;
    int         g;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (prev_ack != 2'b00) chk("ack_pulse", ack, 0);
      if ((WR | RD) && !prev_stb) begin
        if (gq.size() == 0) chk("stb_unexpected", {WR, RD}, 0);
        else begin
          g = gq.pop_front();
          chk("stb_adr", ADR_O, g ? adr1 : adr0);
          chk("stb_kind", {WR, RD}, wr_rq[g] ? 2'b10 : 2'b01);
          chk("stb_dat", DAT_O, wr_rq[g] ? (g ? wdata1 : wdata0) : 32'h0);
        end
      end
      prev_stb = WR | RD;
      prev_ack = ack;
      if (|ack) got++;
    end
    chk("xfer_count", got, n);
  endtask

  initial begin
    reset = 1'b1; wr_rq = 2'b00; rd_rq = 2'b00;
    adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0; DAT_I = '0; BUSY = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", RD, 0);
    chk("rst_wr", WR, 0);
    chk("rst_adr", ADR_O, 0);
    chk("rst_dat", DAT_O, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;

    // single write, no wait states; DAT_I must not leak into rdata
    adr0 = 10'h008; wdata0 = 32'h0000_0003; DAT_I = 32'hFFFF_0000; wr_rq = 2'b01;
    sb.push_back(exp_t'{2'b01, 32'h0, 1'b0});
    @(negedge clk);
    chk("w_wr", WR, 1);
    chk("w_rd", RD, 0);
    chk("w_adr", ADR_O, 10'h008);
    chk("w_dat", DAT_O, 32'h3);
    chk("w_ack_early", ack, 0);
    @(negedge clk);
    chk("w_ack", ack, 2'b01);
    chk("w_wr_drop", WR, 0);
    chk("w_adr_idle", ADR_O, 0);
    wr_rq = 2'b00;
    @(negedge clk);
    chk("w_ack_once", ack, 0);

    // read with three wait states
    adr1 = 10'h002; DAT_I = 32'h1234_5678; BUSY = 1'b1; rd_rq = 2'b10;
    sb.push_back(exp_t'{2'b10, 32'h1234_5678, 1'b0});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("r_rd_held", RD, 1);
      chk("r_adr", ADR_O, 10'h002);
      chk("r_dat_zero", DAT_O, 0);
      chk("r_ack_wait", ack, 0);
      if (k == 4) BUSY = 1'b0;
    end
    @(negedge clk);
    chk("r_ack", ack, 2'b10);
    chk("r_rdata", rdata, 32'h1234_5678);
    chk("r_rd_drop", RD, 0);
    rd_rq = 2'b00; DAT_I = 32'hCAFE_0001;
    @(negedge clk);
    chk("r_rdata_hold", rdata, 32'h1234_5678);

    // contention straight out of reset: 0,1,0,1
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    adr0 = 10'h010; wdata0 = 32'hA5A5_0000; adr1 = 10'h020; DAT_I = 32'h0BAD_F00D;
    wr_rq = 2'b01; rd_rq = 2'b10;
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    sb.push_back(exp_t'{2'b01, 32'h0, 1'b0});
    sb.push_back(exp_t'{2'b10, 32'h0BAD_F00D, 1'b0});
    sb.push_back(exp_t'{2'b01, 32'h0BAD_F00D, 1'b0});
    sb.push_back(exp_t'{2'b10, 32'h0BAD_F00D, 1'b0});
    run_xfers(4, 40);
    wr_rq = 2'b00; rd_rq = 2'b00;
    @(negedge clk);

    // reset in the middle of a stalled read from requester 0
    BUSY = 1'b1; adr0 = 10'h055; rd_rq = 2'b01;
    @(negedge clk);
    chk("rst_mid_rd_before", RD, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rd", RD, 0);
    chk("rst_mid_wr", WR, 0);
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_adr", ADR_O, 0);
    rd_rq = 2'b00;
    @(negedge clk);
    reset = 1'b0; BUSY = 1'b0; wdata1 = 32'h5555_AAAA; wr_rq = 2'b11;
    gq.push_back(0); gq.push_back(1);
    sb.push_back(exp_t'{2'b01, 32'h0, 1'b0});
    sb.push_back(exp_t'{2'b10, 32'h0, 1'b0});
    run_xfers(2, 20);
    wr_rq = 2'b00;
    @(negedge clk);

    // write and read both set on one requester: write only
    adr1 = 10'h1C3; wdata1 = 32'h0000_BEEF; wr_rq = 2'b10; rd_rq = 2'b10;
    gq.push_back(1);
    sb.push_back(exp_t'{2'b10, 32'h0, 1'b0});
    run_xfers(1, 10);
    wr_rq = 2'b00; rd_rq = 2'b00;
    @(negedge clk);

`ifdef TSE_ARB_TIMEOUT_EN
    BUSY = 1'b1; adr1 = 10'h3FF; wdata1 = 32'h1; wr_rq = 2'b10;
    sb.push_back(exp_t'{2'b10, 32'hDEAD_BEEF, 1'b1});
    n_stb = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (WR) n_stb++;
      else break;
    end
    chk("to_stb_len", n_stb, TO);
    chk("to_ack", ack, 2'b10);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 32'hDEAD_BEEF);
    wr_rq = 2'b00;
    @(negedge clk);
    chk("to_err_once", err, 0);
    BUSY = 1'b0;
`else
    BUSY = 1'b1; rd_rq = 2'b10; n_stb = 0; err_seen = 0;
    repeat (2000) begin
      @(negedge clk);
      if (RD) n_stb++;
      if (err) err_seen++;
    end
    chk("nto_stb_len", n_stb, 2000);
    chk("nto_err", err_seen, 0);
    chk("nto_ack", ack, 0);
    reset = 1'b1; rd_rq = 2'b00;
    @(negedge clk);
    reset = 1'b0; BUSY = 1'b0;
`endif

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("gq_empty", gq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
